// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a five-stage pipeline.
// Produces ALU and branch-comparator bypass selects, load-use and branch
// stalls, and sequences the stall window of a multi-cycle mult/div unit.
// A saturating counter records how many cycles the front end was held.

module hazard_unit #(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic        branch_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  writereg_E,
    input  logic        regwrite_E,
    input  logic        memtoreg_E,
    input  logic        md_start_E,
    input  logic [4:0]  writereg_M,
    input  logic        regwrite_M,
    input  logic        memtoreg_M,
    input  logic [4:0]  writereg_W,
    input  logic        regwrite_W,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic        forwardA_D,
    output logic        forwardB_D,
    output logic [1:0]  forwardA_E,
    output logic [1:0]  forwardB_E,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    // The first execute cycle of a multi-cycle op is spent in IDLE, so the
    // counter only has to cover the remaining MD_CYCLES-1 busy cycles.
    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    mdState_t    r_state;
    mdState_t    w_stateNext;
    logic [3:0]  r_mdCnt;
    logic [3:0]  w_mdCntNext;
    logic [15:0] r_stallCnt;
    logic        w_mdBusy;
    logic        w_lwStall;
    logic        w_branchStall;
    logic        w_stall;

    // Execute-stage operand bypass; the younger memory-stage result wins.
    always_comb begin
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        if ((rs_E != 5'd0) && regwrite_M && (rs_E == writereg_M)) begin
            forwardA_E = 2'b10;
        end else if ((rs_E != 5'd0) && regwrite_W && (rs_E == writereg_W)) begin
            forwardA_E = 2'b01;
        end
        if ((rt_E != 5'd0) && regwrite_M && (rt_E == writereg_M)) begin
            forwardB_E = 2'b10;
        end else if ((rt_E != 5'd0) && regwrite_W && (rt_E == writereg_W)) begin
            forwardB_E = 2'b01;
        end
    end

    // Decode-stage comparator bypass from the memory stage only.
    always_comb begin
        forwardA_D = (rs_D != 5'd0) && (rs_D == writereg_M) && regwrite_M;
        forwardB_D = (rt_D != 5'd0) && (rt_D == writereg_M) && regwrite_M;
    end

    // Load-use and branch-operand stalls; register 0 never creates a hazard.
    always_comb begin
        w_lwStall = memtoreg_E && (rt_E != 5'd0) &&
                    ((rs_D == rt_E) || (rt_D == rt_E));
        w_branchStall = branch_D &&
            ((regwrite_E && (writereg_E != 5'd0) &&
              ((writereg_E == rs_D) || (writereg_E == rt_D))) ||
             (memtoreg_M && (writereg_M != 5'd0) &&
              ((writereg_M == rs_D) || (writereg_M == rt_D))));
        w_stall = w_lwStall || w_branchStall || w_mdBusy;
    end

    // Multi-cycle unit state and countdown register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mdCnt <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_mdCnt <= w_mdCntNext;
        end
    end

    // Next-state logic; a start pulse seen while busy is deliberately dropped.
    always_comb begin
        w_stateNext = r_state;
        w_mdCntNext = r_mdCnt;
        case (r_state)
            IDLE: begin
                if (md_start_E) begin
                    w_stateNext = BUSY;
                    w_mdCntNext = MD_LOAD;
                end
            end
            BUSY: begin
                if (r_mdCnt != 4'd0) begin
                    w_mdCntNext = r_mdCnt - 4'd1;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_mdCntNext = 4'd0;
            end
        endcase
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= 16'd0;
        end else if (w_stall && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign w_mdBusy  = (r_state == BUSY);
    assign md_busy   = w_mdBusy;
    assign stall_F   = w_stall;
    assign stall_D   = w_stall;
    assign flush_E   = w_stall;
    assign stall_cnt = r_stallCnt;

endmodule
